// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
// The requester drives start and the operands; the comparator drives status and result flags.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             smaller;
  logic             equal;
  logic             greater;

  modport master (
    output start, a, b,
    input  busy, done, smaller, equal, greater
  );

  modport slave (
    input  start, a, b,
    output busy, done, smaller, equal, greater
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: captures two words, walks them MSB-first one bit
// per clock, stops at the first differing bit and reports a sticky smaller/equal/greater result.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_mag_comparator_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic               smaller_q;
  logic               equal_q;
  logic               greater_q;

  // Operands are shifted left so the bit under test is always the MSB;
  // idx_q only counts the remaining bits so the equal exit happens at bit 0.
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   b_d;
  logic [IDX_W-1:0]   idx_d;
  logic               a_bit;
  logic               b_bit;

  assign a_d   = a_q << 1;
  assign b_d   = b_q << 1;
  assign idx_d = idx_q - 1'b1;
  assign a_bit = a_q[WIDTH-1];
  assign b_bit = b_q[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      smaller_q <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            idx_q     <= IDX_W'(WIDTH - 1);
            smaller_q <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= COMPARE;
          end
        end
        COMPARE: begin
          if (a_bit && !b_bit) begin
            greater_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (!a_bit && b_bit) begin
            smaller_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (idx_q == '0) begin
            equal_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_d;
            a_q   <= a_d;
            b_q   <= b_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.smaller = smaller_q;
  assign bus.equal   = equal_q;
  assign bus.greater = greater_q;

endmodule
